// File: rtl/mvmu_agent_pkg.sv
// Shared types and constants for the MVMU-side MU lane agent.
// The agent RTL that imports this package honours `MVMU_AGENT_PREFETCH_EN (one-entry read prefetch).
package mvmu_agent_pkg;

    localparam int MVMU_I_DEPTH = 256;
    localparam int MEM_WIDTH    = 8;
    localparam int ADDR_W       = 32;
    localparam int DATA_W       = MVMU_I_DEPTH;
    localparam int BATCH_W      = 8;
    localparam int ADDR_STEP    = MVMU_I_DEPTH / MEM_WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_REQ   = 3'd1,
        ST_RD_WAIT  = 3'd2,
        ST_CMP_SEND = 3'd3,
        ST_CMP_RECV = 3'd4,
        ST_WR       = 3'd5,
        ST_DONE     = 3'd6
    } state_t;

    // Byte address of batch idx; wraps modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] batch_addr(input logic [ADDR_W-1:0] src,
                                                     input logic [BATCH_W-1:0] idx);
        return src + ADDR_W'(idx) * ADDR_W'(ADDR_STEP);
    endfunction

endpackage

// File: rtl/mvmu_mem_agent.sv
// MVMU lane agent: fetch a batch from MU, pass it through compute, write the result back.
// Optional `MVMU_AGENT_PREFETCH_EN overlaps the next batch read with the current result wait.
module mvmu_mem_agent
    import mvmu_agent_pkg::*;
(
    input  logic               clk,
    input  logic               RSTn,
    input  logic               start,
    input  logic [ADDR_W-1:0]  cfg_src_addr,
    input  logic [BATCH_W-1:0] cfg_num_batch,
    output logic               busy,
    output logic               done,
    output logic               mu_rd_en,
    output logic [ADDR_W-1:0]  mu_rd_addr,
    input  logic [DATA_W-1:0]  mu_rd_data,
    output logic               mu_wr_en,
    output logic [BATCH_W-1:0] mu_wr_batch,
    output logic [DATA_W-1:0]  mu_wr_data,
    output logic               cmp_in_valid,
    input  logic               cmp_in_ready,
    output logic [DATA_W-1:0]  cmp_in_data,
    input  logic               cmp_out_valid,
    output logic               cmp_out_ready,
    input  logic [DATA_W-1:0]  cmp_out_data
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // cmp_in_valid/cmp_in_data hold steady until that edge, cmp_out_ready is high only in CMP_RECV.

    state_t             state;
    state_t             state_nxt;
    logic [BATCH_W-1:0] idx;
    logic [ADDR_W-1:0]  src_q;
    logic [BATCH_W-1:0] num_q;
    logic [DATA_W-1:0]  in_buf;
    logic [DATA_W-1:0]  out_buf;
    logic               last;

    assign last = (idx == num_q - 8'd1);

`ifdef MVMU_AGENT_PREFETCH_EN
    logic [DATA_W-1:0]  pf_buf;
    logic               pf_vld;
    logic               pf_req;
    logic               pf_cap;
    logic               pf_hit;
    logic               more_left;

    assign more_left = ({1'b0, idx} + 9'd1) < {1'b0, num_q};
    // Read data returning in the WR cycle is forwarded straight into in_buf.
    assign pf_hit    = pf_vld | pf_cap;
`endif

    always_ff @(posedge clk) begin
        if (!RSTn) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (start) state_nxt = (cfg_num_batch == '0) ? ST_DONE : ST_RD_REQ;
            ST_RD_REQ:   state_nxt = ST_RD_WAIT;
            ST_RD_WAIT:  state_nxt = ST_CMP_SEND;
            ST_CMP_SEND: if (cmp_in_ready) state_nxt = ST_CMP_RECV;
            ST_CMP_RECV: if (cmp_out_valid) state_nxt = ST_WR;
`ifdef MVMU_AGENT_PREFETCH_EN
            ST_WR:       state_nxt = last ? ST_DONE : (pf_hit ? ST_CMP_SEND : ST_RD_REQ);
`else
            ST_WR:       state_nxt = last ? ST_DONE : ST_RD_REQ;
`endif
            ST_DONE:     state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!RSTn) begin
            idx     <= '0;
            src_q   <= '0;
            num_q   <= '0;
            in_buf  <= '0;
            out_buf <= '0;
`ifdef MVMU_AGENT_PREFETCH_EN
            pf_buf  <= '0;
            pf_vld  <= 1'b0;
            pf_req  <= 1'b0;
            pf_cap  <= 1'b0;
`endif
        end else begin
            if (state == ST_IDLE && start) begin
                src_q <= cfg_src_addr;
                num_q <= cfg_num_batch;
                idx   <= '0;
            end
            if (state == ST_RD_WAIT) in_buf <= mu_rd_data;
            if (state == ST_CMP_RECV && cmp_out_valid) out_buf <= cmp_out_data;
            if (state == ST_WR && !last) begin
                idx <= idx + 8'd1;
`ifdef MVMU_AGENT_PREFETCH_EN
                if (pf_hit) in_buf <= pf_cap ? mu_rd_data : pf_buf;
`endif
            end
`ifdef MVMU_AGENT_PREFETCH_EN
            // One request on the SEND->RECV transition; data returns the following cycle.
            pf_req <= (state == ST_CMP_SEND) && cmp_in_ready && more_left && !pf_vld;
            pf_cap <= pf_req;
            if (pf_cap) pf_buf <= mu_rd_data;
            if (state == ST_WR && !last && pf_hit) pf_vld <= 1'b0;
            else if (pf_cap)                       pf_vld <= 1'b1;
`endif
        end
    end

    always_comb begin
        busy          = (state != ST_IDLE);
        done          = (state == ST_DONE);
        mu_rd_en      = (state == ST_RD_REQ);
        mu_rd_addr    = (state == ST_RD_REQ) ? batch_addr(src_q, idx) : '0;
        mu_wr_en      = (state == ST_WR);
        mu_wr_batch   = (state == ST_WR) ? idx : '0;
        mu_wr_data    = (state == ST_WR) ? out_buf : '0;
        cmp_in_valid  = (state == ST_CMP_SEND);
        cmp_in_data   = (state == ST_CMP_SEND) ? in_buf : '0;
        cmp_out_ready = (state == ST_CMP_RECV);
`ifdef MVMU_AGENT_PREFETCH_EN
        if (pf_req) begin
            mu_rd_en   = 1'b1;
            mu_rd_addr = batch_addr(src_q, idx + 8'd1);
        end
`endif
    end

endmodule

// File: tb/tb_mvmu_mem_agent.sv
// Scoreboard bench for mvmu_mem_agent with MU and compute responder models.
// Expectations follow `MVMU_AGENT_PREFETCH_EN when it is defined for the build.
module tb_mvmu_mem_agent;
    import mvmu_agent_pkg::*;

    logic               clk = 1'b0;
    logic               RSTn;
    logic               start;
    logic [ADDR_W-1:0]  cfg_src_addr;
    logic [BATCH_W-1:0] cfg_num_batch;
    logic               busy, done;
    logic               mu_rd_en, mu_wr_en;
    logic [ADDR_W-1:0]  mu_rd_addr;
    logic [DATA_W-1:0]  mu_rd_data;
    logic [BATCH_W-1:0] mu_wr_batch;
    logic [DATA_W-1:0]  mu_wr_data;
    logic               cmp_in_valid, cmp_in_ready;
    logic [DATA_W-1:0]  cmp_in_data;
    logic               cmp_out_valid, cmp_out_ready;
    logic [DATA_W-1:0]  cmp_out_data;

    always #5 clk = ~clk;

    mvmu_mem_agent dut (
        .clk(clk), .RSTn(RSTn), .start(start),
        .cfg_src_addr(cfg_src_addr), .cfg_num_batch(cfg_num_batch),
        .busy(busy), .done(done),
        .mu_rd_en(mu_rd_en), .mu_rd_addr(mu_rd_addr), .mu_rd_data(mu_rd_data),
        .mu_wr_en(mu_wr_en), .mu_wr_batch(mu_wr_batch), .mu_wr_data(mu_wr_data),
        .cmp_in_valid(cmp_in_valid), .cmp_in_ready(cmp_in_ready), .cmp_in_data(cmp_in_data),
        .cmp_out_valid(cmp_out_valid), .cmp_out_ready(cmp_out_ready), .cmp_out_data(cmp_out_data)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [ADDR_W-1:0] exp_rd_q[$];
    logic [263:0]      exp_wr_q[$];
    logic [31:0]       exp_done_q[$];
    int                rd_cyc_q[$];
    int                wr_seen   = 0;
    int                done_seen = 0;
    int                busy_cnt  = 0;
    bit                idle_chk  = 0;

    int                stall_len  = 0;
    int                stall_seen = 0;
    logic [DATA_W-1:0] held;

    task automatic chk(input string name, input logic [263:0] act, input logic [263:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input logic [63:0] act);
        tests++;
        fails++;
        $display("FAIL %s: actual %h required none", name, act);
    endtask

    function automatic logic [DATA_W-1:0] mem_word(input logic [31:0] a);
        logic [DATA_W-1:0] w;
        for (int i = 0; i < 8; i++) w[i*32 +: 32] = a ^ (32'h0101_0101 * (i + 1));
        return w;
    endfunction

    function automatic logic [DATA_W-1:0] cmp_result(input logic [DATA_W-1:0] d);
        return {d[0], d[255:1]} ^ {8{32'hC0DE_F00D}};
    endfunction

    // MU model: data for a read strobe is present in the following cycle.
    initial begin
        bit                pend = 0;
        logic [ADDR_W-1:0] pend_addr = '0;
        mu_rd_data = '0;
        forever begin
            @(negedge clk);
            mu_rd_data = pend ? mem_word(pend_addr) : '0;
            pend      = mu_rd_en;
            pend_addr = mu_rd_addr;
        end
    end

    // Compute model: result offered the cycle after an input transfer; optional input stall
    // with a junk result dangled during the stall.
    initial begin
        bit                res_pend = 0;
        bit                out_clr  = 0;
        logic [DATA_W-1:0] res = '0;
        cmp_out_valid = 1'b0;
        cmp_out_data  = '0;
        cmp_in_ready  = 1'b1;
        forever begin
            @(negedge clk);
            if (out_clr) begin
                cmp_out_valid = 1'b0;
                cmp_out_data  = '0;
                out_clr       = 0;
            end
            if (res_pend) begin
                cmp_out_valid = 1'b1;
                cmp_out_data  = res;
                res_pend      = 0;
            end
            if (cmp_out_valid && cmp_out_ready) out_clr = 1;
            if (cmp_in_valid && !cmp_in_ready) begin
                if (stall_seen == 0) held = cmp_in_data;
                else chk("stall_in_data", cmp_in_data, held);
                chk("stall_out_ready", cmp_out_ready, 0);
                chk("stall_rd_en", mu_rd_en, 0);
                chk("stall_wr_en", mu_wr_en, 0);
                stall_seen++;
                if (stall_seen > stall_len) begin
                    cmp_in_ready  = 1'b1;
                    cmp_out_valid = 1'b0;
                    cmp_out_data  = '0;
                end else begin
                    cmp_out_valid = 1'b1;
                    cmp_out_data  = {8{32'hBAD0_BAD0}};
                end
            end
            if (cmp_in_valid && cmp_in_ready) begin
                res_pend = 1;
                res      = cmp_result(cmp_in_data);
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a strobe.
    initial begin
        forever begin
            @(negedge clk);
            if (RSTn) begin
                if (busy) busy_cnt++;
                if (idle_chk) begin
                    chk("busy_after_done", busy, 0);
                    chk("done_width", done, 0);
                    idle_chk = 0;
                end
                if (mu_rd_en) begin
                    rd_cyc_q.push_back(cyc);
                    if (exp_rd_q.size() == 0) flag("rd_unexpected", 64'(mu_rd_addr));
                    else chk("rd_addr", mu_rd_addr, exp_rd_q.pop_front());
                end
                if (mu_wr_en) begin
                    wr_seen++;
                    if (exp_wr_q.size() == 0) flag("wr_unexpected", 64'(mu_wr_batch));
                    else chk("wr_batch_data", {mu_wr_batch, mu_wr_data}, exp_wr_q.pop_front());
                end
                if (done) begin
                    done_seen++;
                    idle_chk = 1;
                    if (exp_done_q.size() == 0) flag("done_unexpected", 64'(cyc));
                    else chk("done_cycle", 32'(cyc), exp_done_q.pop_front());
                    chk("busy_in_done", busy, 1);
                end
`ifndef MVMU_AGENT_PREFETCH_EN
                if (mu_rd_en && mu_wr_en) flag("rd_wr_overlap", 64'(cyc));
`endif
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_rd_en"}, mu_rd_en, 0);
        chk({tag, "_rd_addr"}, mu_rd_addr, 0);
        chk({tag, "_wr_en"}, mu_wr_en, 0);
        chk({tag, "_wr_batch"}, mu_wr_batch, 0);
        chk({tag, "_wr_data"}, mu_wr_data, 0);
        chk({tag, "_in_valid"}, cmp_in_valid, 0);
        chk({tag, "_in_data"}, cmp_in_data, 0);
        chk({tag, "_out_ready"}, cmp_out_ready, 0);
    endtask

    function automatic int job_len(input int num, input int stall);
        if (num == 0) return 1;
`ifdef MVMU_AGENT_PREFETCH_EN
        return 3 * num + 3 + stall;
`else
        return 5 * num + 1 + stall;
`endif
    endfunction

    task automatic push_batches(input logic [31:0] src, input int num);
        for (int i = 0; i < num; i++) begin
            logic [31:0] a;
            a = src + 32'(i) * 32'd32;
            exp_rd_q.push_back(a);
            exp_wr_q.push_back({8'(i), cmp_result(mem_word(a))});
        end
    endtask

    // Called and returns at a falling edge.
    task automatic run_job(input logic [31:0] src, input int num, input int stall, input bit chk_rd2);
        int  k, d0, lat;
        bit  got;
        lat = job_len(num, stall);
        push_batches(src, num);
        stall_len    = stall;
        stall_seen   = 0;
        cmp_in_ready = (stall == 0);
        rd_cyc_q.delete();
        k  = cyc;
        d0 = done_seen;
        exp_done_q.push_back(32'(k + lat));
        busy_cnt      = 0;
        cfg_src_addr  = src;
        cfg_num_batch = 8'(num);
        start         = 1'b1;
        @(negedge clk);
        start         = 1'b0;
        cfg_src_addr  = 32'hDEAD_0000;
        cfg_num_batch = 8'd77;
        got = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done_seen != d0) begin
                got = 1;
                break;
            end
        end
        if (!got) flag("job_timeout", 64'(num));
        repeat (2) @(negedge clk);
        chk("busy_cycles", 32'(busy_cnt), 32'(lat));
        chk("rd_q_drained", 32'(exp_rd_q.size()), 0);
        chk("wr_q_drained", 32'(exp_wr_q.size()), 0);
        if (chk_rd2) begin
            if (rd_cyc_q.size() < 2) flag("rd2_missing", 64'(rd_cyc_q.size()));
`ifdef MVMU_AGENT_PREFETCH_EN
            else chk("rd2_cycle", 32'(rd_cyc_q[1]), 32'(k + 4));
`else
            else chk("rd2_cycle", 32'(rd_cyc_q[1]), 32'(k + 6));
`endif
        end
        exp_rd_q.delete();
        exp_wr_q.delete();
        exp_done_q.delete();
    endtask

    task automatic reset_mid_job();
        int  w0, d0;
        bit  got;
        logic [31:0] src;
        src = 32'h3000;
        for (int i = 0; i < 2; i++) begin
            exp_rd_q.push_back(src + 32'(i) * 32'd32);
            exp_wr_q.push_back({8'(i), cmp_result(mem_word(src + 32'(i) * 32'd32))});
        end
        exp_rd_q.push_back(src + 32'h40);
`ifdef MVMU_AGENT_PREFETCH_EN
        exp_rd_q.push_back(src + 32'h60);
`endif
        stall_len     = 0;
        stall_seen    = 0;
        cmp_in_ready  = 1'b1;
        w0            = wr_seen;
        d0            = done_seen;
        cfg_src_addr  = src;
        cfg_num_batch = 8'd4;
        start         = 1'b1;
        @(negedge clk);
        start = 1'b0;
        got = 0;
        for (int i = 0; i < 100; i++) begin
            if (wr_seen == w0 + 2 && cmp_out_ready) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
        if (!got) flag("reset_point_timeout", 64'(wr_seen));
        RSTn = 1'b0;
        @(negedge clk);
        check_all_zero("midrst");
        RSTn = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_no_done", 32'(done_seen), 32'(d0));
        chk("midrst_wr_count", 32'(wr_seen), 32'(w0 + 2));
        chk("midrst_rd_q", 32'(exp_rd_q.size()), 0);
        chk("midrst_wr_q", 32'(exp_wr_q.size()), 0);
        exp_rd_q.delete();
        exp_wr_q.delete();
    endtask

    initial begin
        RSTn          = 1'b0;
        start         = 1'b0;
        cfg_src_addr  = '0;
        cfg_num_batch = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        RSTn = 1'b1;
        @(negedge clk);

        run_job(32'h0000_1000, 1, 0, 0);
        run_job(32'h0000_0010, 0, 0, 0);
        run_job(32'h0000_2000, 4, 0, 0);
        run_job(32'h0000_5000, 3, 0, 1);
        run_job(32'h0000_6000, 2, 7, 0);
        chk("stall_cycles_seen", 32'(stall_seen), 32'd8);
        reset_mid_job();
        run_job(32'h0000_4000, 2, 0, 0);
        run_job(32'hFFFF_FFC0, 3, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
